// File: rtl/lsu_pkg.sv
// Shared types for the load/store memory port: access sizes, FSM states, alignment helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_e;

  function automatic logic misaligned(input size_e size, input logic [1:0] lo);
    case (size)
      SZ_HALF: misaligned = lo[0];
      SZ_WORD: misaligned = |lo;
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Little-endian lane logic: extract+extend a load lane, or merge store bytes into a read word.
module lsu_lane
  import lsu_pkg::*;
(
  input  size_e       size_i,
  input  logic [1:0]  lane_i,
  input  logic        unsigned_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Half lanes ignore lane_i[0], which also forces misaligned halves onto their aligned lane.
  assign byte_sel = rdata_i[{lane_i, 3'b000} +: 8];
  assign half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    load_o = 32'h0;
    case (size_i)
      SZ_BYTE: load_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      SZ_WORD: load_o = rdata_i;
      default: load_o = 32'h0;
    endcase
  end

  always_comb begin
    merge_o = rdata_i;
    case (size_i)
      SZ_BYTE: merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      SZ_HALF: merge_o = lane_i[1] ? {wdata_i[15:0], rdata_i[15:0]}
                                   : {rdata_i[31:16], wdata_i[15:0]};
      SZ_WORD: merge_o = wdata_i;
      default: merge_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store initiator for a single-port word memory with one-cycle registered read.
// Define LSU_MISALIGN_CHECK_EN to flag misaligned half/word accesses as errors instead of forcing alignment.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_w,
  output logic        mem_r,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic        we_q;
  size_e       size_q;
  logic        unsigned_q;
  logic [1:0]  lo_q;
  logic [31:0] wdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  size_e       req_size_e;
  logic        accept;
  logic        req_err;
  logic [31:0] lane_load;
  logic [31:0] lane_merge;

  assign req_size_e = size_e'(req_size);
  assign req_ready  = (state_q == IDLE) && !reset;
  assign accept     = req_valid && req_ready;

  always_comb begin
    req_err = ({2'b00, req_addr[31:2]} >= MEM_WORDS) || (req_size_e == SZ_RSVD);
`ifdef LSU_MISALIGN_CHECK_EN
    req_err = req_err || misaligned(req_size_e, req_addr[1:0]);
`endif
  end

  lsu_lane u_lane (
    .size_i     (size_q),
    .lane_i     (lo_q),
    .unsigned_i (unsigned_q),
    .rdata_i    (mem_rdata),
    .wdata_i    (wdata_q),
    .load_o     (lane_load),
    .merge_o    (lane_merge)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                  state_d = RESP;
          else if (!req_we)             state_d = RD;
          else if (req_size_e == SZ_WORD) state_d = WR;
          else                          state_d = RD;
        end
      end
      RD:      state_d = CAP;
      CAP:     state_d = we_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      unsigned_q   <= 1'b0;
      lo_q         <= 2'b00;
      wdata_q      <= 32'h0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else if (accept) begin
      we_q         <= req_we;
      size_q       <= req_size_e;
      unsigned_q   <= req_unsigned;
      lo_q         <= req_addr[1:0];
      wdata_q      <= req_wdata;
      mem_addr_q   <= {2'b00, req_addr[31:2]};
      mem_wdata_q  <= req_wdata;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= req_err;
    end else if (state_q == CAP) begin
      // Read word is only valid here: finish the load or build the merged store word.
      if (we_q) mem_wdata_q  <= lane_merge;
      else      resp_rdata_q <= lane_load;
    end
  end

  assign mem_r      = (state_q == RD);
  assign mem_w      = (state_q == WR);
  assign resp_valid = (state_q == RESP);
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a behavioural 32-word registered-read memory.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_w;
  logic        mem_r;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [32];

  lsu_mem_port #(.MEM_WORDS(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_w        (mem_w),
    .mem_r        (mem_r),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
      mem_rdata <= 32'h0;
    end else begin
      if (mem_w) mem[mem_addr[4:0]] <= mem_wdata;
      if (mem_r) mem_rdata <= mem[mem_addr[4:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One request; latency/strobe cycles are counted from the accept edge (cycle 1 follows it).
  task automatic run_req(input string tag, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                         input int exp_lat, input logic exp_err, input logic [31:0] exp_rd,
                         input int exp_rcyc, input int exp_wcyc);
    int lat = 0, rcyc = 0, wcyc = 0, nstrobe = 0;
    logic both = 1'b0;
    logic got_err = 1'b0;
    logic [31:0] got_rd = 32'h0, waddr = 32'h0;
    @(negedge clk);
    chk({tag, ".ready_idle"}, {31'h0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) chk({tag, ".ready_busy"}, {31'h0, req_ready}, 32'd0);
      if (mem_r && mem_w) both = 1'b1;
      if (mem_r) begin rcyc = c; nstrobe++; end
      if (mem_w) begin wcyc = c; waddr = mem_addr; nstrobe++; end
      if (resp_valid) begin lat = c; got_err = resp_err; got_rd = resp_rdata; end
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".err"}, {31'h0, got_err}, {31'h0, exp_err});
    chk({tag, ".rdata"}, got_rd, exp_rd);
    chk({tag, ".rd_cycle"}, rcyc, exp_rcyc);
    chk({tag, ".wr_cycle"}, wcyc, exp_wcyc);
    chk({tag, ".strobes"}, nstrobe + (both ? 100 : 0),
        (exp_rcyc != 0 ? 1 : 0) + (exp_wcyc != 0 ? 1 : 0));
    if (wcyc != 0) chk({tag, ".wr_addr"}, waddr, {2'b00, addr[31:2]});
  endtask

  initial begin
    int late_w, late_resp;
    repeat (2) @(negedge clk);
    chk("rst.ready", {31'h0, req_ready}, 32'd0);
    chk("rst.resp_valid", {31'h0, resp_valid}, 32'd0);
    chk("rst.resp_err", {31'h0, resp_err}, 32'd0);
    chk("rst.resp_rdata", resp_rdata, 32'h0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk("rst.mem_wdata", mem_wdata, 32'h0);
    chk("rst.strobes", {30'h0, mem_w, mem_r}, 32'h0);
    reset = 1'b0;

    run_req("sw08",   1, 2'b10, 0, 32'h08, 32'hDEADBEEF, 2, 0, 32'h0,        0, 1);
    run_req("lw08",   0, 2'b10, 0, 32'h08, 32'h0,        3, 0, 32'hDEADBEEF, 1, 0);
    run_req("sb09",   1, 2'b00, 0, 32'h09, 32'hAAAAAA55, 4, 0, 32'h0,        1, 3);
    run_req("lw08b",  0, 2'b10, 0, 32'h08, 32'h0,        3, 0, 32'hDEAD55EF, 1, 0);
    run_req("lb0b",   0, 2'b00, 0, 32'h0B, 32'h0,        3, 0, 32'hFFFFFFDE, 1, 0);
    run_req("lbu0b",  0, 2'b00, 1, 32'h0B, 32'h0,        3, 0, 32'h000000DE, 1, 0);
    run_req("lh0a",   0, 2'b01, 0, 32'h0A, 32'h0,        3, 0, 32'hFFFFDEAD, 1, 0);
    run_req("lhu08",  0, 2'b01, 1, 32'h08, 32'h0,        3, 0, 32'h000055EF, 1, 0);
    run_req("lb09",   0, 2'b00, 0, 32'h09, 32'h0,        3, 0, 32'h00000055, 1, 0);
    run_req("lw80",   0, 2'b10, 0, 32'h80, 32'h0,        1, 1, 32'h0,        0, 0);
    run_req("lrsvd",  0, 2'b11, 0, 32'h08, 32'h0,        1, 1, 32'h0,        0, 0);
    run_req("sw80",   1, 2'b10, 0, 32'h80, 32'h12345678, 1, 1, 32'h0,        0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    run_req("lw0a",   0, 2'b10, 0, 32'h0A, 32'h0,        1, 1, 32'h0,        0, 0);
`else
    run_req("lw0a",   0, 2'b10, 0, 32'h0A, 32'h0,        3, 0, 32'hDEAD55EF, 1, 0);
`endif
    run_req("sh0e",   1, 2'b01, 0, 32'h0E, 32'hFFFF1234, 4, 0, 32'h0,        1, 3);
    run_req("lw0c",   0, 2'b10, 0, 32'h0C, 32'h0,        3, 0, 32'h12340000, 1, 0);
    run_req("sh0c",   1, 2'b01, 0, 32'h0C, 32'h0000BEEF, 4, 0, 32'h0,        1, 3);
    run_req("lw0cb",  0, 2'b10, 0, 32'h0C, 32'h0,        3, 0, 32'h1234BEEF, 1, 0);

    // Abort a byte store while it is reading.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h77;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort.in_rd", {31'h0, mem_r}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort.ready_in_reset", {31'h0, req_ready}, 32'd0);
    reset = 1'b0;
    late_w = 0; late_resp = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) chk("abort.ready_after", {31'h0, req_ready}, 32'd1);
      if (mem_w) late_w++;
      if (resp_valid) late_resp++;
    end
    chk("abort.no_write", late_w, 0);
    chk("abort.no_resp", late_resp, 0);
    run_req("lw10",   0, 2'b10, 0, 32'h10, 32'h0,        3, 0, 32'h0,        1, 0);
    run_req("lw08c",  0, 2'b10, 0, 32'h08, 32'h0,        3, 0, 32'h0,        1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store initiator driving the single-port word data memory from the core's execute stage. Accepts one byte-addressed load or store per valid/ready handshake and converts it to word-indexed memory strobes. Handles the memory's one-cycle registered read and performs read-modify-write for byte/halfword stores. Returns a one-cycle response pulse with data or an error flag.

## Interface
- MEM_WORDS, 32, memory depth in 32-bit words; must equal the attached memory's size
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high; shared with the memory
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready at posedge clk
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  loads: 1 zero-extend, 0 sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualified by resp_valid
- mem_addr  out  32  word index = req_addr >> 2
- mem_wdata  out  32  full word to write
- mem_w  out  1  memory write strobe
- mem_r  out  1  memory read strobe
- mem_rdata  in  32  memory read data, valid the cycle after a mem_r edge

## Operation
- Moore FSM states: IDLE, RD, CAP, WR, RESP.
- req_ready = (state == IDLE) && !reset. Request fields latched on acceptance.
- Accept routing: error -> RESP; load -> RD; word store -> WR; byte/half store -> RD.
- RD: mem_r=1, mem_w=0. Next: CAP.
- CAP: mem_rdata valid. Load: extract lane, extend, register into resp_rdata -> RESP. Sub-word store: merge store bytes into the read word, register into mem_wdata -> WR.
- WR: mem_w=1, mem_r=0. Next: RESP.
- RESP: resp_valid=1 for exactly one cycle. Next: IDLE.
- mem_w and mem_r are never both 1. Both are 0 outside RD/WR.
- Lanes are little-endian. Byte lane = addr[1:0] (lane 0 = bits 7:0). Half lane = addr[1] (0 = bits 15:0). Word ignores addr[1:0].
- Error cases: word index >= MEM_WORDS, or req_size == 11. resp_err=1, resp_rdata=0, no memory strobe is issued.

## Timing
- Accept edge = E0. Cycle in which resp_valid is high:
  - error: cycle 1
  - word store: cycle 2 (memory written at E1)
  - load: cycle 3
  - byte/half store: cycle 4 (read at E1, write at E3)
- Throughput is one request per latency + 1 cycles. No pipelining; req_ready is 0 from E0 until back in IDLE.
- Reset values: state IDLE; resp_valid 0, resp_err 0, resp_rdata 0, mem_addr 0, mem_wdata 0, mem_w 0, mem_r 0.
- Reset mid-operation aborts the transaction. No strobe is issued after the reset edge, no response is produced, and a pending store is lost. The memory clears simultaneously.
- req_valid held while not ready is not consumed. The request is accepted on the first IDLE cycle.

## Configuration
- LSU_MISALIGN_CHECK_EN defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, is an error (resp_err, no strobe).
- Undefined: the offending low address bits are ignored and the access is forced aligned.

## Structure
- Shared package lsu_pkg holds:
  - size_e enum: SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD
  - state_e enum: IDLE, RD, CAP, WR, RESP
- Sub-module lsu_lane (combinational) handles both lane extract+extend (loads) and lane merge (stores), selected by size, addr[1:0] and unsigned. Instantiated once.

## Test plan
- Store word 0xDEADBEEF at addr 0x08, then load word at 0x08 -> mem_w pulse with mem_addr=2; resp_rdata=0xDEADBEEF, resp_err=0; resp_valid at cycles 2 and 3 after their accept edges.
- After the word above, store byte 0x55 at 0x09, then load word at 0x08 -> RD then WR sequence; load returns 0xDEAD55EF.
- Byte load at 0x0B, signed -> 0xFFFFFFDE; unsigned -> 0x000000DE. Half load at 0x0A, signed -> 0xFFFFDEAD.
- Load at addr 0x80 (index 32, MEM_WORDS=32) -> resp_valid in cycle 1 with resp_err=1, rdata 0; mem_r and mem_w stay 0.
- Word load at 0x0A -> with LSU_MISALIGN_CHECK_EN: resp_err=1; without: returns the word at index 2.
- Assert reset during the RD of a byte store -> no mem_w afterwards, no resp_valid, req_ready=1 the cycle after reset deasserts.
